if_fetch_ctrl: RTL



---
 rtl/if_fetch_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one request at a time to a variable-latency
// instruction memory, gates the PC register, and owns the IF/ID register with skid buffer.
module if_fetch_ctrl #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_Out,
    output logic        PCWrite,
    input  logic        flush,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic        kill, kill_nx;
    logic [31:0] req_pc;
    logic [31:0] buf_pc, buf_instr;
    logic        deliver, take_buf, load_buf;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        kill_nx  = kill;
        imem_req = 1'b0;
        deliver  = 1'b0;
        take_buf = 1'b0;
        load_buf = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                kill_nx  = kill | flush;
                state_nx = WAIT;
            end
            WAIT: begin
                if (!imem_rvalid) begin
                    kill_nx = kill | flush;
                end else if (kill || flush) begin
                    kill_nx  = 1'b0;
                    state_nx = FETCH;
                end else if (!stall_id) begin
                    deliver  = 1'b1;
                    state_nx = FETCH;
                end else begin
                    load_buf = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nx = FETCH;
                end else if (!stall_id) begin
                    deliver  = 1'b1;
                    take_buf = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
        // Reset forces the request low so the memory sees nothing while rst is held.
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    assign PCWrite   = !rst && (flush || deliver);
    assign imem_addr = PC_Out;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the skid buffer is reset as well so its contents are never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            kill        <= 1'b0;
            req_pc      <= 32'd0;
            buf_pc      <= 32'd0;
            buf_instr   <= 32'd0;
            IF_ID_PC    <= 32'd0;
            IF_ID_Instr <= NOP;
            IF_ID_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            if (imem_req) begin
                req_pc <= PC_Out;
            end
            if (load_buf) begin
                buf_pc    <= req_pc;
                buf_instr <= imem_rdata;
            end
            // Flush beats stall beats delivery; an idle cycle inserts a bubble.
            if (flush) begin
                IF_ID_valid <= 1'b0;
                IF_ID_Instr <= NOP;
                IF_ID_PC    <= 32'd0;
            end else if (!stall_id) begin
                if (deliver) begin
                    IF_ID_valid <= 1'b1;
                    IF_ID_PC    <= take_buf ? buf_pc : req_pc;
                    IF_ID_Instr <= take_buf ? buf_instr : imem_rdata;
                end else begin
                    IF_ID_valid <= 1'b0;
                    IF_ID_Instr <= NOP;
                end
            end
            if (deliver) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
